peg_l2_mii_tx_ser: RTL and testbench
====================================

Name: peg_l2_mii_tx_ser

Overview:
- Parametrised MAC-side transmit serializer that generalises the RMII transmit path.
- PHY datapath width is selectable: 2 bits for RMII, 4 bits for MII.
- Supports 10/100 speed modes; inserts preamble and SFD; enforces inter-packet gap (IPG).
- Sits between the L2 MAC frame/FCS stage (byte stream) and the PHY pins (txd/tx_en).

Parameters:
- PHY_DATA_W, 2: symbol width on txd; legal values 2 or 4.
- PREAMBLE_BYTES, 7: number of 0x55 bytes sent before the SFD.
- IPG_BYTES, 12: minimum idle gap, in byte times, after tx_en deasserts.
- SLOW_DIV, 10: ref_clk cycles per symbol in 10 Mbps mode.

Ports:
- ref_clk  input  1  symbol clock; the only clock.
- rst_n  input  1  synchronous reset, active low.
- speed_100  input  1  1 = 100 Mbps (one symbol per cycle); 0 = 10 Mbps (one symbol per SLOW_DIV cycles).
- tx_data  input  8  frame byte from MAC.
- tx_valid  input  1  tx_data/tx_sop/tx_eop are valid.
- tx_sop  input  1  first byte of frame (destination address byte 0).
- tx_eop  input  1  last byte of frame (FCS byte 3).
- tx_ready  output  1  byte accepted this cycle (transfer = tx_valid & tx_ready).
- txd  output  PHY_DATA_W  PHY transmit data.
- tx_en  output  1  PHY transmit enable.
- tx_busy  output  1  FSM not in IDLE.
- pkt_done  output  1  one-cycle pulse when the last data symbol is driven.
- underrun  output  1  one-cycle pulse when a byte is starved mid-frame.

Behaviour:
- Reset (rst_n low at a ref_clk edge): FSM=IDLE; all counters 0; txd=0, tx_en=0, tx_ready=0, tx_busy=0, pkt_done=0, underrun=0.
  - Reset mid-frame aborts immediately; tx_en drops on the next edge.
- Symbol strobe sym_stb:
  - speed_100=1: high every cycle.
  - speed_100=0: high when the divider counter equals SLOW_DIV-1; counter wraps to 0.
  - speed_100 is latched into speed_q only in IDLE; changes mid-frame are ignored.
- SYMS = 8/PHY_DATA_W symbols per byte. Bytes are shifted out LSB-first.
- txd and tx_en are registered and update only on sym_stb; they hold between strobes.
- FSM states and transitions:
  - IDLE: tx_valid & tx_sop → PREAMBLE (byte not consumed). tx_valid & !tx_sop → discard the byte (tx_ready=1), stay in IDLE.
  - PREAMBLE: drive the 0x55 pattern (dibit 01 or nibble 5) for PREAMBLE_BYTES*SYMS strobes with tx_en=1, then → SFD.
  - SFD: drive 0xD5 LSB-first (dibits 01,01,01,11; nibbles 5,D).
    - On the strobe carrying the last SFD symbol, load the SOP byte: tx_ready=1 in that cycle; tx_valid is guaranteed high.
    - → DATA.
  - DATA: shift the loaded byte out.
    - On the strobe of its last symbol, if it was not eop: tx_ready=1.
      - tx_valid=1 → load the next byte, continue.
      - tx_valid=0 → underrun pulse; tx_en=0 from the next strobe; → DROP.
    - If the byte was eop: pkt_done pulse; tx_en=0 from the next strobe; → IPG.
  - DROP: tx_ready=1 continuously; discard bytes until tx_valid & tx_eop, then → IPG.
  - IPG: tx_en=0 and txd=0 for IPG_BYTES*SYMS strobes, then → IDLE. sop is not honoured before IPG completes.
- Latency: first preamble symbol appears on txd at the first sym_stb after the sop is seen in IDLE (1 cycle in 100 mode).
- Frame timing: tx_en high for exactly (PREAMBLE_BYTES+1+N)*SYMS strobes for an N-byte frame.
- tx_ready is a combinational function of state, strobe and symbol counter; it does not depend on tx_valid.
- Single-byte frame (sop & eop together) is legal and goes straight to IPG after 1 data byte.
- tx_sop seen in DATA is treated as ordinary data. No re-sync is performed; upstream guarantees framing.

Test Plan:
- W=2, 100 mode, 4-byte frame {0x12,0x34,0x56,0x78} → tx_en high 48 cycles; first 28 txd=01; SFD 01,01,01,11; then 0x12 as 10,00,01,00; pkt_done on the last data symbol; tx_en low for 48 cycles after.
- W=4, 100 mode, 64-byte frame → tx_en high (8+64)*2=144 cycles; nibbles LSB-first (0xA5 → 5,A); 4 tx_ready pulses per 8 cycles... exactly 64 transfers total.
- W=2, 10 mode (SLOW_DIV=10), 1-byte frame → each symbol held 10 cycles; tx_en high 9*4*10=360 cycles; IPG 480 cycles.
- Underrun: drop tx_valid for 1 byte slot at byte 5 of 20 → underrun pulse once; tx_en low from the next strobe; remaining bytes drained with tx_ready=1; no pkt_done.
- Back-to-back frames with sop held valid during IPG → second preamble starts exactly IPG_BYTES*SYMS strobes after tx_en fall.
- rst_n low mid-DATA for 1 cycle → all outputs 0 next edge; non-sop bytes afterwards are discarded; next sop frame is serialised normally.

Source files
------------

// File: rtl/peg_l2_mii_tx_ser_if.sv
// Byte-stream handshake between the L2 MAC frame/FCS stage and the PHY transmit serializer.
// A byte transfers on a ref_clk edge when tx_valid and tx_ready are both high.
interface peg_l2_mii_tx_ser_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_sop;
   logic       tx_eop;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, output tx_sop, output tx_eop, input tx_ready);
   modport slave  (input tx_data, input tx_valid, input tx_sop, input tx_eop, output tx_ready);
endinterface

// File: rtl/peg_l2_mii_tx_ser.sv
// MAC-side RMII/MII transmit serializer: preamble + SFD insertion, LSB-first byte shifting,
// underrun drop handling and inter-packet gap, at 10 or 100 Mbps on a single symbol clock.
module peg_l2_mii_tx_ser #(
   parameter int PHY_DATA_W     = 2,
   parameter int PREAMBLE_BYTES = 7,
   parameter int IPG_BYTES      = 12,
   parameter int SLOW_DIV       = 10
) (
   input  logic                  ref_clk,
   input  logic                  rst_n,
   input  logic                  speed_100,
   peg_l2_mii_tx_ser_if.slave    mac,
   output logic [PHY_DATA_W-1:0] txd,
   output logic                  tx_en,
   output logic                  tx_busy,
   output logic                  pkt_done,
   output logic                  underrun
);
   localparam int SYMS     = 8 / PHY_DATA_W;
   localparam int PRE_SYMS = PREAMBLE_BYTES * SYMS;
   localparam int IPG_SYMS = IPG_BYTES * SYMS;
   localparam int CNT_W    = 16;
   localparam int DIV_W    = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam logic [7:0] PRE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;
   localparam logic [PHY_DATA_W-1:0] PRE_SYM = PRE_BYTE[PHY_DATA_W-1:0];

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_SFD      = 3'd2,
      ST_DATA     = 3'd3,
      ST_DROP     = 3'd4,
      ST_IPG      = 3'd5
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic                    speed_q, speed_d;
   logic [7:0]              sh_q, sh_d;
   logic                    eop_q, eop_d;
   logic [PHY_DATA_W-1:0]   txd_q, txd_d;
   logic                    tx_en_q, tx_en_d;
   logic                    busy_q;
   logic                    done_q, done_d;
   logic                    und_q, und_d;
   logic                    speed_eff_s;
   logic                    sym_stb_s;
   logic                    tx_ready_s;
   logic [7:0]              sfd_sh_s;

   // Symbol strobe: in IDLE the live speed input applies so a new frame starts at its own rate.
   always_comb begin
      speed_eff_s = (state_q == ST_IDLE) ? speed_100 : speed_q;
      sym_stb_s   = 1'b1;
      div_d       = '0;
      if (speed_eff_s) begin
         sym_stb_s = 1'b1;
         div_d     = '0;
      end else begin
         sym_stb_s = (div_q == DIV_W'(SLOW_DIV - 1));
         div_d     = sym_stb_s ? '0 : div_q + DIV_W'(1);
      end
   end

   // Transmit FSM next-state, shifter and registered PHY outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      eop_d      = eop_q;
      txd_d      = txd_q;
      tx_en_d    = tx_en_q;
      speed_d    = speed_q;
      done_d     = 1'b0;
      und_d      = 1'b0;
      tx_ready_s = 1'b0;
      sfd_sh_s   = SFD_BYTE >> (cnt_q[2:0] * 3'(PHY_DATA_W));
      case (state_q)
         ST_IDLE: begin
            speed_d    = speed_100;
            cnt_d      = '0;
            tx_ready_s = ~mac.tx_sop;
            // The sop byte is not consumed here; it is loaded at the end of the SFD.
            if (mac.tx_valid && mac.tx_sop && sym_stb_s) begin
               txd_d   = PRE_SYM;
               tx_en_d = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = ST_PREAMBLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PREAMBLE: begin
            if (sym_stb_s) begin
               txd_d   = PRE_SYM;
               tx_en_d = 1'b1;
               if (cnt_q == CNT_W'(PRE_SYMS - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_SFD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_PREAMBLE;
            end
         end
         ST_SFD: begin
            if (sym_stb_s) begin
               txd_d   = sfd_sh_s[PHY_DATA_W-1:0];
               tx_en_d = 1'b1;
               if (cnt_q == CNT_W'(SYMS - 1)) begin
                  tx_ready_s = 1'b1;
                  sh_d       = mac.tx_data;
                  eop_d      = mac.tx_eop;
                  cnt_d      = '0;
                  state_d    = ST_DATA;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_SFD;
            end
         end
         ST_DATA: begin
            if (sym_stb_s) begin
               txd_d   = sh_q[PHY_DATA_W-1:0];
               tx_en_d = 1'b1;
               sh_d    = sh_q >> PHY_DATA_W;
               if (cnt_q == CNT_W'(SYMS - 1)) begin
                  cnt_d = '0;
                  if (eop_q) begin
                     done_d  = 1'b1;
                     state_d = ST_IPG;
                  end else if (mac.tx_valid) begin
                     tx_ready_s = 1'b1;
                     sh_d       = mac.tx_data;
                     eop_d      = mac.tx_eop;
                  end else begin
                     // Starved mid-frame: abandon the frame and swallow the rest of it.
                     tx_ready_s = 1'b1;
                     und_d      = 1'b1;
                     state_d    = ST_DROP;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_DROP: begin
            tx_ready_s = 1'b1;
            cnt_d      = '0;
            if (sym_stb_s) begin
               txd_d   = '0;
               tx_en_d = 1'b0;
            end else begin
               tx_en_d = tx_en_q;
            end
            if (mac.tx_valid && mac.tx_eop) begin
               state_d = ST_IPG;
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_IPG: begin
            if (sym_stb_s) begin
               txd_d   = '0;
               tx_en_d = 1'b0;
               if (cnt_q == CNT_W'(IPG_SYMS - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_IPG;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            txd_d   = '0;
            tx_en_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge ref_clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         speed_q <= 1'b0;
         sh_q    <= '0;
         eop_q   <= 1'b0;
         txd_q   <= '0;
         tx_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         speed_q <= speed_d;
         sh_q    <= sh_d;
         eop_q   <= eop_d;
         txd_q   <= txd_d;
         tx_en_q <= tx_en_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= done_d;
         und_q   <= und_d;
      end
   end

   assign mac.tx_ready = tx_ready_s & rst_n;
   assign txd          = txd_q;
   assign tx_en        = tx_en_q;
   assign tx_busy      = busy_q;
   assign pkt_done     = done_q;
   assign underrun     = und_q;
endmodule

// File: tb/tb_peg_l2_mii_tx_ser.sv
// Directed bench for peg_l2_mii_tx_ser: a table of frame scenarios on RMII and MII instances,
// plus hand-written back-to-back and mid-frame reset sequences.
module tb_peg_l2_mii_tx_ser;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       spd;
   logic [7:0] d_data;
   logic       d_valid, d_sop, d_eop;
   logic [1:0] txd2;
   logic [3:0] txd4;
   logic       en2, en4, busy2, busy4, done2, done4, und2, und4;

   peg_l2_mii_tx_ser_if if2();
   peg_l2_mii_tx_ser_if if4();
   assign if2.tx_data  = d_data;
   assign if2.tx_valid = d_valid;
   assign if2.tx_sop   = d_sop;
   assign if2.tx_eop   = d_eop;
   assign if4.tx_data  = d_data;
   assign if4.tx_valid = d_valid;
   assign if4.tx_sop   = d_sop;
   assign if4.tx_eop   = d_eop;

   peg_l2_mii_tx_ser #(.PHY_DATA_W(2)) dut2 (
      .ref_clk(clk), .rst_n(rst_n), .speed_100(spd), .mac(if2.slave),
      .txd(txd2), .tx_en(en2), .tx_busy(busy2), .pkt_done(done2), .underrun(und2));
   peg_l2_mii_tx_ser #(.PHY_DATA_W(4)) dut4 (
      .ref_clk(clk), .rst_n(rst_n), .speed_100(spd), .mac(if4.slave),
      .txd(txd4), .tx_en(en4), .tx_busy(busy4), .pkt_done(done4), .underrun(und4));

   typedef struct { logic [7:0] d; logic s; logic e; } src_t;
   typedef struct {
      bit w4; bit spd; int nbytes; int stall_at; int ncyc;
      int exp_en; int exp_done; int exp_und; int exp_xfer;
   } vec_t;

   src_t       src_q[$];
   logic [3:0] lg_txd[$];
   logic       lg_en[$], lg_done[$], lg_und[$], lg_busy[$];
   int         br[$], bl[$];
   int         xfers;
   int         n_vec = 0;
   int         n_err = 0;
   vec_t       vt[7];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; d_valid = 1'b0; d_sop = 1'b0; d_eop = 1'b0; d_data = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic add_frame(input int n, input logic [7:0] seed);
      for (int i = 0; i < n; i++) begin
         src_t t;
         t.d = seed + 8'(i) * 8'h22;
         t.s = (i == 0);
         t.e = (i == n - 1);
         src_q.push_back(t);
      end
   endtask

   // One iteration per ref_clk cycle; log[k] holds outputs after the (k+1)th edge of the run.
   task automatic run(input bit w4, input int ncyc, input int stall_at, input int stall_len,
                      input int rst_at);
      int idx = 0;
      int stall_left = 0;
      bit stall_used = 1'b0;
      bit xfer;
      lg_txd.delete(); lg_en.delete(); lg_done.delete(); lg_und.delete(); lg_busy.delete();
      xfers = 0;
      for (int k = 0; k < ncyc; k++) begin
         if (!stall_used && stall_at >= 0 && idx == stall_at) begin
            stall_left = stall_len;
            stall_used = 1'b1;
         end
         if (idx < src_q.size() && stall_left == 0) begin
            d_data = src_q[idx].d; d_sop = src_q[idx].s; d_eop = src_q[idx].e; d_valid = 1'b1;
         end else begin
            d_data = 8'h00; d_sop = 1'b0; d_eop = 1'b0; d_valid = 1'b0;
         end
         rst_n = (k == rst_at) ? 1'b0 : 1'b1;
         @(negedge clk);
         xfer = d_valid & (w4 ? if4.tx_ready : if2.tx_ready);
         @(posedge clk);
         #1;
         if (xfer) begin
            idx++;
            xfers++;
         end
         if (stall_left > 0) stall_left--;
         lg_txd.push_back(w4 ? txd4 : {2'b00, txd2});
         lg_en.push_back(w4 ? en4 : en2);
         lg_done.push_back(w4 ? done4 : done2);
         lg_und.push_back(w4 ? und4 : und2);
         lg_busy.push_back(w4 ? busy4 : busy2);
      end
      rst_n = 1'b1; d_valid = 1'b0; d_sop = 1'b0; d_eop = 1'b0;
   endtask

   task automatic find_bursts();
      br.delete(); bl.delete();
      for (int k = 0; k < lg_en.size(); k++) begin
         if (lg_en[k] && (k == 0 || !lg_en[k-1])) br.push_back(k);
         if (lg_en[k] && (k == lg_en.size() - 1 || !lg_en[k+1])) bl.push_back(k);
      end
   endtask

   function automatic int count_of(input bit which_und);
      int c = 0;
      for (int k = 0; k < lg_done.size(); k++) c += which_und ? int'(lg_und[k]) : int'(lg_done[k]);
      return c;
   endfunction

   function automatic int first_pulse();
      for (int k = 0; k < lg_done.size(); k++) if (lg_done[k] || lg_und[k]) return k;
      return -1;
   endfunction

   // Expected symbol j of a frame whose first byte sits at src_q[fs].
   function automatic logic [3:0] exp_sym(input bit w4, input int j, input int fs);
      int syms = w4 ? 2 : 4;
      int w    = w4 ? 4 : 2;
      int pre  = 7 * syms;
      int part, rel, bi;
      logic [7:0] b, sh;
      if (j < pre) begin
         b = 8'h55; part = 0;
      end else if (j < pre + syms) begin
         b = 8'hD5; part = j - pre;
      end else begin
         rel  = j - pre - syms;
         bi   = fs + rel / syms;
         b    = (bi < src_q.size()) ? src_q[bi].d : 8'h00;
         part = rel % syms;
      end
      sh = b >> (part * w);
      return w4 ? sh[3:0] : {2'b00, sh[1:0]};
   endfunction

   task automatic sym_chk(input string name, input bit w4, input int hold, input int bi,
                          input int fs);
      int bad = 0;
      for (int k = br[bi]; k <= bl[bi]; k++)
         if (lg_txd[k] !== exp_sym(w4, (k - br[bi]) / hold, fs)) bad++;
      chk(name, bad, 0);
   endtask

   initial begin
      rst_n = 1'b0; spd = 1'b1;
      d_data = 8'h00; d_valid = 1'b0; d_sop = 1'b0; d_eop = 1'b0;
      //         w4    spd   n   stall ncyc  en   done und xfer
      vt[0] = '{1'b0, 1'b1,  4,  -1,  150,  48,  1,   0,  4};
      vt[1] = '{1'b0, 1'b1,  1,  -1,  100,  36,  1,   0,  1};
      vt[2] = '{1'b0, 1'b1, 20,   5,  250,  52,  0,   1, 20};
      vt[3] = '{1'b0, 1'b1,  3,   1,  150,  36,  0,   1,  3};
      vt[4] = '{1'b0, 1'b0,  1,  -1,  900, 360,  1,   0,  1};
      vt[5] = '{1'b1, 1'b1, 64,  -1,  300, 144,  1,   0, 64};
      vt[6] = '{1'b1, 1'b1,  1,  -1,  100,  18,  1,   0,  1};

      // Outputs while reset is held
      repeat (2) @(posedge clk);
      #1;
      chk("rst_txd", int'(txd2), 0);
      chk("rst_en", int'(en2), 0);
      chk("rst_ready", int'(if2.tx_ready), 0);
      chk("rst_busy", int'(busy2), 0);
      chk("rst_pulses", int'(done2) + int'(und2), 0);

      for (int i = 0; i < 7; i++) begin
         vec_t v;
         int hold, syms;
         v    = vt[i];
         hold = v.spd ? 1 : 10;
         syms = v.w4 ? 2 : 4;
         spd  = v.spd;
         do_reset();
         src_q.delete();
         add_frame(v.nbytes, 8'h12);
         run(v.w4, v.ncyc, v.stall_at, syms * hold, -1);
         find_bursts();
         chk($sformatf("v%0d_bursts", i), br.size(), 1);
         if (br.size() >= 1) begin
            chk($sformatf("v%0d_en_len", i), bl[0] - br[0] + 1, v.exp_en);
            chk($sformatf("v%0d_latency", i), (br[0] < hold) ? 1 : 0, 1);
            sym_chk($sformatf("v%0d_symbols", i), v.w4, hold, 0, 0);
            chk($sformatf("v%0d_pulse_pos", i), first_pulse(), bl[0] - (hold - 1));
         end
         chk($sformatf("v%0d_pkt_done", i), count_of(1'b0), v.exp_done);
         chk($sformatf("v%0d_underrun", i), count_of(1'b1), v.exp_und);
         chk($sformatf("v%0d_xfers", i), xfers, v.exp_xfer);
         chk($sformatf("v%0d_busy_end", i), int'(lg_busy[v.ncyc - 1]), 0);
      end

      // Back-to-back frames: second sop is waiting throughout the gap
      spd = 1'b1;
      do_reset();
      src_q.delete();
      add_frame(2, 8'h40);
      add_frame(2, 8'h90);
      run(1'b0, 200, -1, 0, -1);
      find_bursts();
      chk("b2b_bursts", br.size(), 2);
      if (br.size() >= 2) begin
         chk("b2b_len0", bl[0] - br[0] + 1, 40);
         chk("b2b_gap", br[1] - (bl[0] + 1), 48);
         chk("b2b_len1", bl[1] - br[1] + 1, 40);
         sym_chk("b2b_symbols1", 1'b0, 1, 1, 2);
      end
      chk("b2b_pkt_done", count_of(1'b0), 2);

      // One-cycle reset in the middle of DATA, then stale bytes, then a fresh frame
      do_reset();
      src_q.delete();
      add_frame(20, 8'h12);
      add_frame(4, 8'h21);
      run(1'b0, 250, -1, 0, 40);
      find_bursts();
      chk("mid_en_before", int'(lg_en[39]), 1);
      chk("mid_en_after", int'(lg_en[40]), 0);
      chk("mid_txd_after", int'(lg_txd[40]), 0);
      chk("mid_busy_after", int'(lg_busy[40]), 0);
      chk("mid_bursts", br.size(), 2);
      if (br.size() >= 2) begin
         chk("mid_restart", br[1], 58);
         chk("mid_len1", bl[1] - br[1] + 1, 48);
         sym_chk("mid_symbols1", 1'b0, 1, 1, 20);
      end
      chk("mid_pkt_done", count_of(1'b0), 1);
      chk("mid_xfers", xfers, 24);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
